// File: rtl/cs_pkg.sv
// Shared types and defaults for the carry-save resolver.
package cs_pkg;
    localparam int WIDTH_92      = 92;
    localparam int CHUNK_DEFAULT = 23;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cs_state_e;
endpackage

// File: rtl/cs_chunk_add.sv
// One CHUNK-bit slice of the carry-propagate adder.
module cs_chunk_add #(
    parameter int W = 23
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
endmodule

// File: rtl/cs_resolve_92.sv
// Resolves a carry-save pair to binary, one CHUNK-bit slice per cycle.
module cs_resolve_92
    import cs_pkg::*;
#(
    parameter int WIDTH = WIDTH_92,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("cs_resolve_92: WIDTH must be a multiple of CHUNK");
    end

    cs_state_e        state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_r;
    logic             slice_co;
    logic             last;

    assign slice_a = c_q[int'(idx_q)*CHUNK +: CHUNK];
    assign slice_b = s_q[int'(idx_q)*CHUNK +: CHUNK];
    assign last    = (idx_q == IW'(NCHUNK - 1));

    cs_chunk_add #(
        .W(CHUNK)
    ) u_add (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .cin_i (cin_q),
        .sum_o (slice_r),
        .cout_o(slice_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cin_d    = cin_q;
        c_d      = c_q;
        s_d      = s_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    c_d     = in_c;
                    s_d     = in_s;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_r;
                cin_d = slice_co;
                if (last) begin
                    carry_d = slice_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Retire and accept share one edge when both sides are ready.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        c_d     = in_c;
                        s_d     = in_s;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            c_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            c_q     <= c_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
endmodule

// File: tb/tb_cs_resolve_92.sv
// Scoreboard bench for cs_resolve_92: directed corners, backpressure, reset, random.
module tb_cs_resolve_92;
    localparam int W = 92;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_c = '0;
    logic [W-1:0] in_s = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t last_exp;

    cs_resolve_92 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_c     (in_c),
        .in_s     (in_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand92();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic exp_t model(logic [W-1:0] c, logic [W-1:0] s);
        exp_t       e;
        logic [W:0] t;
        t       = {1'b0, c} + {1'b0, s};
        e.sum   = t[W-1:0];
        e.carry = t[W];
        return e;
    endfunction

    // Offer a pair from IDLE; returns at edge k + #1.
    task automatic offer(logic [W-1:0] c, logic [W-1:0] s);
        in_c     = c;
        in_s     = s;
        in_valid = 1'b1;
        #1;
        check("accept_rdy", 128'(in_ready), 128'(1));
        sb.push_back(model(c, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_c     = rand92();
        in_s     = rand92();
    endtask

    task automatic await_result(string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(4));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
            e        = sb.pop_front();
            last_exp = e;
            check({tag, "_sum"}, 128'(out_sum), 128'(e.sum));
            check({tag, "_carry"}, 128'(out_carry), 128'(e.carry));
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("retire_idle", 128'(out_valid), 128'(0));
    endtask

    task automatic directed(string tag, logic [W-1:0] c, logic [W-1:0] s);
        offer(c, s);
        await_result(tag);
        retire();
    endtask

    task automatic run_random(int n);
        int           sent, got, guard;
        logic [W-1:0] x, y, z, c, s;
        logic         have;
        exp_t         e, r;
        sent  = 0;
        got   = 0;
        guard = 0;
        have  = 1'b0;
        while (got < n && guard < 90000) begin
            if (!have && sent < n) begin
                x    = rand92();
                y    = rand92();
                z    = rand92();
                s    = x ^ y ^ z;
                c    = ((x & y) | (x & z) | (y & z)) << 1;
                have = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) != 0);
            in_valid  = have;
            in_c      = have ? c : rand92();
            in_s      = have ? s : rand92();
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_sb_empty", 128'(0), 128'(1));
                end else begin
                    r = sb.pop_front();
                    check("rnd_sum", 128'(out_sum), 128'(r.sum));
                    check("rnd_carry", 128'(out_carry), 128'(r.carry));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                e       = model(c, s);
                e.sum   = x + y + z;
                sb.push_back(e);
                sent++;
                have = 1'b0;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_done", 128'(got), 128'(n));
    endtask

    initial begin
        logic [W-1:0] one, top, all1;
        int           seen;
        one  = 1;
        top  = one << 91;
        all1 = '1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_sum", 128'(out_sum), 128'(0));
        check("rst_carry", 128'(out_carry), 128'(0));
        rst_n = 1'b1;
        #1;
        check("rst_ready", 128'(in_ready), 128'(1));

        directed("zero", '0, '0);
        directed("b23", one, (one << 23) - 1);
        directed("b69", one, (one << 69) - 1);
        directed("wrap", one, all1);
        directed("top", top, top);

        // Backpressure: hold a result while a new pair waits.
        offer(rand92(), rand92());
        await_result("bp");
        in_c     = (one << 46) - 1;
        in_s     = one;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_sum", 128'(out_sum), 128'(last_exp.sum));
            check("bp_carry", 128'(out_carry), 128'(last_exp.carry));
            check("bp_inrdy", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        #1;
        check("b2b_inrdy", 128'(in_ready), 128'(1));
        sb.push_back(model(in_c, in_s));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_run", 128'(out_valid), 128'(0));
        await_result("b2b");
        retire();

        // Reset during the second RUN cycle.
        offer(all1, all1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_sum", 128'(out_sum), 128'(0));
        check("mrst_carry", 128'(out_carry), 128'(0));
        check("mrst_inrdy", 128'(in_ready), 128'(1));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mrst_spurious", 128'(seen), 128'(0));

        run_random(10000);
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
